// File: rtl/ecall_io_unit.sv
// ecall I/O service unit.
// Read requests stall the core until a debounced confirm press, then deliver
// decoded switch data for write-back to a0. Write requests update the LED or
// 7-segment value register in a single cycle without stalling.
module ecall_io_unit #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IORead,
    input  logic        IOWrite,
    input  logic [31:0] rega7,
    input  logic [31:0] rega0,
    input  logic [15:0] switch_in,
    input  logic        btn_confirm,
    output logic        io_stall,
    output logic [31:0] io_rdata,
    output logic        io_rdata_valid,
    output logic [15:0] led_out,
    output logic [31:0] seg_value
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_REL   = 2'd1,
        WAIT_PRESS = 2'd2,
        DONE       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t            state;
    state_t            state_next;
    logic [15:0]       sw_meta;
    logic [15:0]       sw_sync;
    logic              btn_meta;
    logic              btn_sync;
    logic              btn_stable;
    logic [CNT_W-1:0]  db_cnt;
    logic              read_latch;
    logic [31:0]       rdata_dec;

    // Only the low three bits of a7 select the service.
    logic              unused_a7_high;
    assign unused_a7_high = ^rega7[31:3];

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sw_meta  <= switch_in;
            sw_sync  <= sw_meta;
            btn_meta <= btn_confirm;
            btn_sync <= btn_meta;
        end
    end

    // Debounce: accept a new button level only after it persists for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_stable <= 1'b0;
            db_cnt     <= '0;
        end else if (btn_sync == btn_stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            btn_stable <= btn_sync;
            db_cnt     <= '0;
        end else begin
            db_cnt <= db_cnt + CNT_W'(1);
        end
    end

    // Read-handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; stall asserts in the same cycle a read arrives.
    always_comb begin
        state_next     = state;
        io_stall       = 1'b0;
        io_rdata_valid = 1'b0;
        read_latch     = 1'b0;
        case (state)
            IDLE: begin
                if (IORead) begin
                    io_stall   = 1'b1;
                    state_next = WAIT_REL;
                end
            end
            WAIT_REL: begin
                io_stall = 1'b1;
                if (!btn_stable) begin
                    state_next = WAIT_PRESS;
                end
            end
            WAIT_PRESS: begin
                io_stall = 1'b1;
                if (btn_stable) begin
                    read_latch = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                io_rdata_valid = 1'b1;
                state_next     = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data formatting selected by a7.
    always_comb begin
        rdata_dec = '0;
        case (rega7[2:0])
            3'd0:    rdata_dec = {16'b0, sw_sync};
            3'd1:    rdata_dec = {{16{sw_sync[15]}}, sw_sync};
            3'd2:    rdata_dec = {24'b0, sw_sync[7:0]};
            3'd3:    rdata_dec = {{24{sw_sync[7]}}, sw_sync[7:0]};
            default: rdata_dec = {16'b0, sw_sync};
        endcase
    end

    // Read data register, held until the next confirmed read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_rdata <= '0;
        end else if (read_latch) begin
            io_rdata <= rdata_dec;
        end
    end

    // Output registers written by ecall; a simultaneous read request suppresses the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out   <= '0;
            seg_value <= '0;
        end else if (IOWrite && !IORead) begin
            case (rega7[2:0])
                3'd4:    led_out   <= rega0[15:0];
                3'd5:    seg_value <= rega0;
                default: ;
            endcase
        end
    end

endmodule
